// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store unit sitting between the execute stage
//               and a ready/valid data bus. Aligns and lane-replicates store
//               data, builds byte strobes, extracts and sign/zero-extends load
//               data, flags misaligned accesses and aborts hung accesses after
//               TIMEOUT cycles.
// Ports       :
//   clk, reset          clock / synchronous active-high reset
//   mem_read, mem_write access request from execute (write wins)
//   funct3              access size/sign (B, H, W, BU, HU; others = W)
//   addr, write_data    byte address and store data
//   stall               hold the core while the access is in flight
//   done, load_data     completion pulse and extended load result
//   misaligned          misaligned access, rejected without bus traffic
//   bus_err             timeout abort, pulsed together with done
//   bus_req/we/addr/wstrb/wdata, bus_ready   request channel
//   bus_rvalid, bus_rdata                    read response channel
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter only ever needs to reach TIMEOUT-1.
  localparam int            CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;

  // Latched request
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [31:2]      word_addr_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;
  logic [31:0]      ld_q;
  logic             err_q;

  // Request decode
  logic             access;
  logic             is_byte;
  logic             is_half;
  logic             mis;
  logic             timeout;
  logic [3:0]       wstrb_new;
  logic [31:0]      wdata_new;
  logic [31:0]      ld_ext;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign access  = mem_read | mem_write;
  // funct3[1:0] == 00 covers B/BU, 01 covers H/HU; everything else is a word.
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);
  assign mis     = is_byte ? 1'b0 : (is_half ? addr[0] : (addr[1:0] != 2'b00));
  assign timeout = (cnt == CNT_LAST);

  // Store strobes and lane-replicated data; a load requests no byte enables.
  always_comb begin
    wstrb_new = 4'b0000;
    wdata_new = 32'd0;
    if (mem_write) begin
      if (is_byte) begin
        wstrb_new = 4'b0001 << addr[1:0];
        wdata_new = {4{write_data[7:0]}};
      end else if (is_half) begin
        wstrb_new = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{write_data[15:0]}};
      end else begin
        wstrb_new = 4'b1111;
        wdata_new = write_data;
      end
    end
  end

  // Load lane extraction from the incoming bus word.
  always_comb begin
    rd_byte = 8'd0;
    case (lane_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_ext = {24'd0, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (mis) begin
            misaligned = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // The abort takes precedence over a handshake in the final cycle.
        if (timeout) begin
          state_nx = DONE;
        end else if (bus_ready) begin
          state_nx = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (timeout || bus_rvalid) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      word_addr_q <= 30'd0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      ld_q        <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (state_nx == REQ) begin
            we_q        <= mem_write;
            f3_q        <= funct3;
            lane_q      <= addr[1:0];
            word_addr_q <= addr[31:2];
            wstrb_q     <= wstrb_new;
            wdata_q     <= wdata_new;
            ld_q        <= 32'd0;
            err_q       <= 1'b0;
          end
        end
        REQ: begin
          cnt   <= cnt + 1'b1;
          err_q <= timeout;
        end
        WAIT: begin
          cnt   <= cnt + 1'b1;
          err_q <= timeout;
          if (!timeout && bus_rvalid) begin
            ld_q <= ld_ext;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign done      = (state == DONE);
  assign bus_err   = done & err_q;
  assign load_data = done ? ld_q : 32'd0;
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {word_addr_q, 2'b00} : 32'd0;
  assign bus_wstrb = bus_req ? wstrb_q : 4'd0;
  assign bus_wdata = bus_req ? wdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A bus responder with
//               programmable ready/rvalid delays drives the DUT; expected
//               results come from an arithmetic model of the access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .write_data(write_data),
    .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'd0;
    addr       = 32'd0;
    write_data = 32'd0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  // One access. dr: REQ cycles with ready low before acceptance;
  // dv: cycles from acceptance to rvalid (>=1); rd: read word returned.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int dr, input int dv,
                           input logic [31:0] rd);
    bit          half_sz, byte_sz, exp_mis, exp_err, finished, acc;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load, sh;
    int          e_stall, nstall, reqcnt, since, total;

    // Reference model
    byte_sz = (f3 == 3'b000) || (f3 == 3'b100);
    half_sz = (f3 == 3'b001) || (f3 == 3'b101);
    if (byte_sz)      exp_mis = 1'b0;
    else if (half_sz) exp_mis = (a % 2) != 0;
    else              exp_mis = (a % 4) != 0;

    if (!we)          e_strb = 4'd0;
    else if (byte_sz) e_strb = 4'(1 << (a % 4));
    else if (half_sz) e_strb = 4'(3 << (a % 4));
    else              e_strb = 4'hF;
    if (byte_sz)      e_wdata = (wd & 32'hFF) * 32'h01010101;
    else if (half_sz) e_wdata = (wd & 32'hFFFF) * 32'h00010001;
    else              e_wdata = wd;

    sh = rd >> (8 * (a % 4));
    case (f3)
      3'b000:  e_load = 32'($signed(sh[7:0]));
      3'b100:  e_load = sh & 32'hFF;
      3'b001:  e_load = 32'($signed(sh[15:0]));
      3'b101:  e_load = sh & 32'hFFFF;
      default: e_load = rd;
    endcase

    total   = we ? dr + 1 : dr + dv + 1;   // REQ+WAIT cycles on success
    exp_err = we ? (dr >= TO - 1) : (dr >= TO - 1) || (dr + dv >= TO - 1);
    e_stall = exp_err ? TO + 1 : total + 1;
    if (exp_err) e_load = 32'd0;

    @(posedge clk); #1;
    mem_write  = we;
    mem_read   = we ? 1'($urandom_range(0, 1)) : 1'b1;
    funct3     = f3;
    addr       = a;
    write_data = wd;
    bus_rdata  = rd;

    if (exp_mis) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_busreq", 32'(bus_req), 32'd0);
        check("mis_load", load_data, 32'd0);
      end
      @(posedge clk); #1;
      idle_inputs();
      return;
    end

    finished = 0; acc = 0; nstall = 0; reqcnt = 0; since = 0;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      @(negedge clk);
      if (done) begin
        finished = 1;
        check("done_stall", 32'(stall), 32'd0);
        check("stall_cycles", 32'(nstall), 32'(e_stall));
        check("bus_err", 32'(bus_err), 32'(exp_err));
        if (!we) check("load_data", load_data, e_load);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
      end else begin
        if (stall) nstall++;
        if (bus_req) begin
          check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
          check("bus_we", 32'(bus_we), 32'(we));
          check("bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
          if (we) check("bus_wdata", bus_wdata, e_wdata);
          bus_ready  = (reqcnt == dr);
          bus_rvalid = 1'($urandom_range(0, 1));  // must be ignored in REQ
          if (bus_ready) acc = 1;
          reqcnt++;
        end else begin
          bus_ready = 1'b0;
          if (acc) begin
            since++;
            bus_rvalid = (since == dv);
          end else begin
            bus_rvalid = 1'b0;
          end
        end
      end
    end
    if (!finished) check("done_seen", 32'd0, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    idle_inputs();
    bus_rdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busreq", 32'(bus_req), 32'd0);
    check("rst_busaddr", bus_addr, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    do_access(1'b0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEADBEEF);  // LW
    do_access(1'b0, 3'b000, 32'h103, 32'd0, 0, 1, 32'h80112233);  // LB
    do_access(1'b0, 3'b100, 32'h103, 32'd0, 0, 1, 32'h80112233);  // LBU
    do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 1, 32'd0);  // SH
    do_access(1'b0, 3'b010, 32'h101, 32'd0, 0, 1, 32'd0);         // misaligned LW
    do_access(1'b0, 3'b010, 32'h200, 32'd0, 100, 1, 32'h12345678);// ready stuck
    do_access(1'b0, 3'b001, 32'h206, 32'd0, 2, TO, 32'h89AB7654); // rvalid too late
    do_access(1'b1, 3'b000, 32'h301, 32'h000000C3, 3, 1, 32'd0);  // SB

    // Reset while waiting for the read response
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);                       // IDLE
    @(negedge clk);                       // REQ
    check("rw_req", 32'(bus_req), 32'd1);
    bus_ready = 1'b1;
    @(negedge clk);                       // WAIT
    check("rw_wait_stall", 32'(stall), 32'd1);
    bus_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_read = 1'b0;
    bus_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_done", 32'(done), 32'd0);
      check("rw_stall", 32'(stall), 32'd0);
      check("rw_busreq", 32'(bus_req), 32'd0);
      check("rw_load", load_data, 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();

    // Randomized accesses
    for (int n = 0; n < 150; n++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom), 32'($urandom),
                $urandom_range(0, 9), $urandom_range(1, 8), 32'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
